// File: rtl/sub_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the subtractor arbiter.
package sub_arbiter_pkg;

    localparam int MAX_REQ = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } sub_arb_state_e;

    // Search starts one past the last grant and wraps modulo n; first hit wins.
    function automatic logic [MAX_REQ-1:0] rr_grant(
        input logic [MAX_REQ-1:0] req,
        input int                 last,
        input int                 n
    );
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        int                 idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = (last + k) % n;
            if (!found && (k <= n) && req[idx[3:0]]) begin
                gnt[idx[3:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: one-hot grant plus its index.
module rr_arbiter
    import sub_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] gnt_ext;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        gnt_ext                = rr_grant(req_ext, int'(last_grant), NUM_REQ);
        grant                  = gnt_ext[NUM_REQ-1:0];
        grant_any              = |gnt_ext;
        grant_idx              = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/sub_arbiter.sv
// Round-robin sequencer sharing one external subtractor among NUM_REQ requesters.
// Optional borrow output enabled by defining SUB_ARBITER_BORROW_EN.
module sub_arbiter
    import sub_arbiter_pkg::*;
#(
    parameter int OPERAND_WIDTH = 32,
    parameter int NUM_REQ       = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_lhs,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_rhs,
    output logic [NUM_REQ-1:0]               rsp_valid,
    input  logic [NUM_REQ-1:0]               rsp_ready,
    output logic [OPERAND_WIDTH-1:0]         rsp_result,
`ifdef SUB_ARBITER_BORROW_EN
    output logic                             rsp_borrow,
`endif
    output logic [OPERAND_WIDTH-1:0]         sub_lhs,
    output logic [OPERAND_WIDTH-1:0]         sub_rhs,
    input  logic [OPERAND_WIDTH-1:0]         sub_result
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sub_arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]         owner_q, owner_d;
    logic [IDX_W-1:0]         last_q, last_d;
    logic [OPERAND_WIDTH-1:0] lhs_q, lhs_d;
    logic [OPERAND_WIDTH-1:0] rhs_q, rhs_d;
    logic [OPERAND_WIDTH-1:0] res_q, res_d;
`ifdef SUB_ARBITER_BORROW_EN
    logic                     borrow_q, borrow_d;
`endif

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        lhs_d     = lhs_q;
        rhs_d     = rhs_q;
        res_d     = res_q;
`ifdef SUB_ARBITER_BORROW_EN
        borrow_d  = borrow_q;
`endif
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                // Gated by rst so nothing is offered while reset is held.
                if (rst && grant_any) begin
                    req_ready = grant;
                    owner_d   = grant_idx;
                    last_d    = grant_idx;
                    state_d   = ISSUE;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant[i]) begin
                            lhs_d = req_lhs[i*OPERAND_WIDTH +: OPERAND_WIDTH];
                            rhs_d = req_rhs[i*OPERAND_WIDTH +: OPERAND_WIDTH];
                        end
                    end
                end
            end
            ISSUE: begin
                res_d    = sub_result;
`ifdef SUB_ARBITER_BORROW_EN
                borrow_d = (lhs_q < rhs_q);
`endif
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready[owner_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            last_q   <= IDX_W'(NUM_REQ - 1);
            lhs_q    <= '0;
            rhs_q    <= '0;
            res_q    <= '0;
`ifdef SUB_ARBITER_BORROW_EN
            borrow_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            lhs_q    <= lhs_d;
            rhs_q    <= rhs_d;
            res_q    <= res_d;
`ifdef SUB_ARBITER_BORROW_EN
            borrow_q <= borrow_d;
`endif
        end
    end

    assign rsp_valid  = (state_q == RESP) ? (NUM_REQ'(1) << owner_q) : '0;
    assign rsp_result = res_q;
    assign sub_lhs    = lhs_q;
    assign sub_rhs    = rhs_q;
`ifdef SUB_ARBITER_BORROW_EN
    assign rsp_borrow = borrow_q;
`endif

endmodule

// File: doc/sub_arbiter.md
# sub_arbiter

Round-robin arbiter and sequencer that shares one combinational `SubOp` subtraction unit among `NUM_REQ` requesters in the ALU arithmetic cluster. It accepts one operand pair at a time over valid/ready handshakes and drives the shared subtractor from registered operands. It captures the difference and returns it to the granted requester over a per-requester response handshake. The subtractor is injected through the operand/result ports below and is never instantiated inside this block.

## Interface
- `OPERAND_WIDTH`, default 32: bitwidth of operands and result.
- `NUM_REQ`, default 4: number of requesters. Legal range is 2..16.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester request accept; at most one bit high.
- `req_lhs`  in  NUM_REQ×OPERAND_WIDTH  per-requester minuend.
- `req_rhs`  in  NUM_REQ×OPERAND_WIDTH  per-requester subtrahend.
- `rsp_valid`  out  NUM_REQ  per-requester response valid; at most one bit high.
- `rsp_ready`  in  NUM_REQ  per-requester response accept.
- `rsp_result`  out  OPERAND_WIDTH  shared response data, meaningful only where `rsp_valid` is high.
- `sub_lhs`  out  OPERAND_WIDTH  operand driven to the shared subtractor.
- `sub_rhs`  out  OPERAND_WIDTH  operand driven to the shared subtractor.
- `sub_result`  in  OPERAND_WIDTH  `sub_lhs - sub_rhs` from the shared subtractor, combinational.

## Operation
- The FSM has three states: IDLE, ISSUE and RESP. The reset state is IDLE.
- **IDLE**
  - The round-robin arbiter picks the first `req_valid[i]`, searching from `(last_grant+1) mod NUM_REQ` upward with wrap-around.
  - `req_ready[i]` is asserted combinationally for the winner only.
  - On the handshake, the block latches `req_lhs[i]` and `req_rhs[i]` into the operand registers, latches `i` into `owner`, sets `last_grant <= i`, and moves to ISSUE.
  - With no valid requests, the block stays in IDLE.
- **ISSUE**
  - `sub_lhs` and `sub_rhs` present the operand registers.
  - At the end of the cycle, the block captures `sub_result` into the result register and moves to RESP.
- **RESP**
  - `rsp_valid[owner]=1` and `rsp_result` equals the result register.
  - Both are held stable until `rsp_ready[owner]`; the block then returns to IDLE.
  - `rsp_ready` on non-owner bits is ignored.
- `req_ready` is all-zero outside IDLE. Requests asserted outside IDLE wait; the block never drops them.
- Arithmetic is modulo 2^OPERAND_WIDTH and unsigned wrap. Example: 0 − 1 = all-ones.
- `sub_lhs` and `sub_rhs` are driven continuously from the operand registers and hold their last value outside ISSUE.
- Reset values: state=IDLE, `last_grant=NUM_REQ-1` so requester 0 wins first, `owner=0`, and operand and result registers are 0. Consequently `req_ready=0`, `rsp_valid=0`, `rsp_result=0`, `sub_lhs=0` and `sub_rhs=0` during reset.
- Reset asserted mid-operation aborts the in-flight operation. No response is produced, and the requester must reissue.

## Timing
- Request handshake at cycle T: operands appear on `sub_*` at T+1, and `rsp_valid` rises at T+2.
- Response handshake at cycle R: IDLE at R+1, with the next grant possible in R+1.
- Peak throughput is one operation per 3 cycles. A contended requester waits at most `NUM_REQ-1` operations.
- `req_ready` depends combinationally on `req_valid` and state. `rsp_valid` and `rsp_result` are registered-only, with no combinational path from `rsp_ready`.
- `sub_result` must settle within one `clk` period after `sub_lhs` and `sub_rhs` change.

## Configuration
- Macro: `SUB_ARBITER_BORROW_EN`.
- **Defined**
  - Adds the output port `rsp_borrow` (1 bit), which is 1 iff the latched lhs < latched rhs (unsigned).
  - It is registered alongside the result in ISSUE, valid with `rsp_valid`, and resets to 0.
- **Undefined**
  - The port and its register are absent; all other behaviour is identical.

## Structure
- **Package `sub_arbiter_pkg`**
  - State enum `sub_arb_state_e` (IDLE, ISSUE, RESP).
  - Parameterisable round-robin helper function returning a one-hot grant from a request vector and the last-grant index.
- **Sub-module `rr_arbiter`**
  - Combinational round-robin pick: inputs are the request vector and `last_grant`; outputs are a one-hot grant and its index.
  - `sub_arbiter` owns the FSM, the registers and the `last_grant` update.

## Test plan
- Reset with `req_valid=4'b1111` held: all outputs are 0 during reset. After release, requester 0 is granted first, then 1, 2, 3, then 0 again.
- Single op, requester 2, lhs=100, rhs=58, `rsp_ready` tied high: `req_ready[2]` at T, `sub_lhs=100`/`sub_rhs=58` at T+1, and `rsp_valid[2]=1` with `rsp_result=42` at T+2. The next grant is possible at T+3.
- Wrap case, lhs=0 and rhs=1, with `OPERAND_WIDTH=8`: result is 8'hFF. With `SUB_ARBITER_BORROW_EN`, `rsp_borrow=1`; for 5−3, `rsp_borrow=0`.
- Response backpressure: `rsp_ready[owner]` held low for 5 cycles. `rsp_valid` and `rsp_result` stay stable, `req_ready` stays 0 despite other valids, and the next grant comes one cycle after the handshake.
- Fairness: requesters 1 and 3 continuously valid. Grants alternate 1, 3, 1, 3, and neither is granted twice in a row while the other is waiting.
- Reset asserted while in ISSUE: no `rsp_valid` is ever raised for the aborted op. After reset, the FSM is in IDLE and requester 0 has priority.
